// File: rtl/accu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// accu_rr_scheduler
//
// Shares one accumulate datapath between NUM_CH requesters. A round-robin
// arbiter grants one channel at a time. The grant stays locked for a group of
// GROUP_LEN beats, which are summed. The group sum and the id of the channel
// that produced it are then offered on a valid/ready output port.
//
// Ports:
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous, active-high reset
//   req_valid  in   NUM_CH          per-channel sample valid
//   req_data   in   NUM_CH*DATA_W   per-channel sample, ch i at [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_CH          per-channel accept, one-hot or zero
//   out_valid  out  1               group sum valid
//   out_ready  in   1               downstream accepts the sum
//   out_data   out  SUM_W           group sum
//   out_ch     out  CH_W            channel that produced out_data
//   busy       out  1               high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module accu_rr_scheduler #(
    parameter  int NUM_CH    = 4,
    parameter  int DATA_W    = 8,
    parameter  int GROUP_LEN = 4,
    localparam int SUM_W     = DATA_W + $clog2(GROUP_LEN),
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SUM_W-1:0]           out_data,
    output logic [CH_W-1:0]            out_ch,
    output logic                       busy
);

    localparam int CNT_W = $clog2(GROUP_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    state_e              state_q,      state_d;
    logic [CH_W-1:0]     grant_q,      grant_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    beat_cnt_q,   beat_cnt_d;
    logic [SUM_W-1:0]    sum_q,        sum_d;
    logic                out_valid_q,  out_valid_d;
    logic [SUM_W-1:0]    out_data_q,   out_data_d;
    logic [CH_W-1:0]     out_ch_q,     out_ch_d;

    // -------------------------------------------------------------------------
    // Round-robin search: first valid channel starting at last_grant+1, wrapping.
    // -------------------------------------------------------------------------
    logic            arb_found;
    logic [CH_W-1:0] arb_ch;
    int              arb_idx;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        arb_found = 1'b0;
        arb_ch    = '0;
        arb_idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            arb_idx = (int'(last_grant_q) + i) % NUM_CH;
            if (!arb_found && req_valid[arb_idx]) begin
                arb_found = 1'b1;
                arb_ch    = CH_W'(arb_idx);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Grant decode. req_ready depends on state and grant only, never on
    // req_valid, so it cannot form a combinational path back to the sources.
    // -------------------------------------------------------------------------
    logic              beat_valid;
    logic [DATA_W-1:0] beat_data;

    always_comb begin
        req_ready  = '0;
        beat_valid = 1'b0;
        beat_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == CH_W'(i)) begin
                req_ready[i] = (state_q == ST_ACCUM);
                beat_valid   = req_valid[i];
                beat_data    = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    logic             beat_acc;
    logic             last_beat;
    logic [SUM_W-1:0] beat_ext;
    logic [SUM_W-1:0] sum_next;

    assign beat_acc  = (state_q == ST_ACCUM) && beat_valid;
    assign last_beat = (beat_cnt_q == CNT_W'(GROUP_LEN - 1));
    assign beat_ext  = {{(SUM_W-DATA_W){1'b0}}, beat_data};
    // The first beat of a group loads the sum, so nothing from an earlier or
    // aborted group can leak into it.
    assign sum_next  = (beat_cnt_q == '0) ? beat_ext : (sum_q + beat_ext);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        sum_d        = sum_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_ch;
                    state_d = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                // A low req_valid on the granted channel just stalls the group.
                if (beat_acc) begin
                    sum_d      = sum_next;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        out_valid_d = 1'b1;
                        out_data_d  = sum_next;
                        out_ch_d    = grant_q;
                        state_d     = ST_OUTPUT;
                    end
                end
            end

            ST_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    last_grant_d = grant_q;
                    beat_cnt_d   = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            beat_cnt_q   <= '0;
            sum_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            sum_q        <= sum_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
